// File: rtl/inv_mix_columns_if.sv
// Handshake bundle for the iterative InvMixColumns engine: upstream state in, transformed state out.
// Bit 0 of each 128-bit vector is the MSB; column c occupies bits [32c:32c+31].
interface inv_mix_columns_if;
    logic         in_valid;
    logic         in_ready;
    logic [0:127] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [0:127] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/inv_mix_columns.sv
// Iterative AES InvMixColumns: captures one 128-bit state, runs one column per clock through a
// single shared GF(2^8) column unit, then holds the result until the consumer takes it.
module inv_mix_columns (
    input  logic             clk,
    input  logic             n_rst,
    inv_mix_columns_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   r_state;
    logic [1:0]   r_col;
    logic [0:127] r_src;
    logic [0:127] r_out_data;

    logic [1:0]   w_state_nxt;
    logic [6:0]   w_col_base;
    logic [0:31]  w_col_in;
    logic [0:31]  w_col_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // s[0] is the top row; each row byte is built from its x2/x4/x8 multiples.
    function automatic logic [0:31] inv_mix_col(input logic [0:31] c);
        logic [7:0] s  [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            s[i]  = c[8*i +: 8];
            x2    = xtime(s[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ s[i];
            mb[i] = x8 ^ x2 ^ s[i];
            md[i] = x8 ^ x4 ^ s[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    assign w_col_base = {r_col, 5'b0};
    assign w_col_in   = r_src[w_col_base +: 32];
    assign w_col_out  = inv_mix_col(w_col_in);

    // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)   w_state_nxt = ST_CALC;
            ST_CALC: if (r_col == 2'd3)  w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready)  w_state_nxt = ST_IDLE;
            default:                     w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: source and result registers are plain flops, so clearing them on reset is cheap and
    // guarantees an aborted block leaves nothing stale on out_data.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_col      <= 2'd0;
            r_src      <= '0;
            r_out_data <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_src <= bus.in_data;
                        r_col <= 2'd0;
                    end
                end
                ST_CALC: begin
                    r_out_data[w_col_base +: 32] <= w_col_out;
                    r_col                        <= r_col + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs decode registered state only.
    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.out_data  = r_out_data;

endmodule
